cache_sa_lru: RTL and testbench
===============================

Name: cache_sa_lru

Overview:
Parametrised N-way set-associative, tag-only cache model that succeeds the direct-mapped hit/miss cache. It takes one address lookup per cycle under a valid handshake and returns hit/miss one cycle later. On a miss it fills the line using true-LRU replacement. It keeps saturating hit and miss counters so benches can read the hit rate directly instead of counting per cycle, and it supports a single-cycle flush and a statistics clear.

Parameters:
ADDR_W, 32, address width in bits.
SETS, 16, number of sets; power of 2, at least 2.
WAYS, 4, associativity; power of 2, at least 2.
BLOCK_BYTES, 16, line size in bytes; power of 2, at least 1.
CNT_W, 32, width of the hit and miss counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  lookup request this cycle.
req_addr  in  ADDR_W  byte address (the instruction word in the existing bench).
flush  in  1  invalidate all lines this cycle.
clr_stats  in  1  zero both counters this cycle.
resp_valid  out  1  response valid; a registered copy of the accepted req_valid.
hit  out  1  lookup result; meaningful only while resp_valid=1.
hit_way  out  log2(WAYS)  way that hit or was filled.
hit_count  out  CNT_W  saturating hit total.
miss_count  out  CNT_W  saturating miss total.

Behaviour:
- Address split: offset = low log2(BLOCK_BYTES) bits (ignored). Index = next log2(SETS) bits. Tag = remaining upper bits.
- Per-line state: valid bit, tag, and age in 0..WAYS-1. Within each set the ages always form a permutation of 0..WAYS-1.
- Reset (async, any time, including mid-stream): every line is invalid, and age of way w = w in every set. resp_valid, hit, hit_way, hit_count and miss_count all return to 0. No request is in flight after reset.
- Request handling: there is no backpressure; a request is accepted whenever req_valid=1, rst=0 and flush=0.
- Latency: exactly 1 cycle. resp_valid, hit and hit_way are registered and appear the cycle after acceptance. Back-to-back requests give back-to-back responses.
- Lookup: hit when any valid way in the indexed set has a matching tag. At most one way can match.
- Miss victim selection: the lowest-index invalid way if one exists; otherwise the way with age WAYS-1. The victim is loaded with valid=1 and the new tag.
- LRU update for the accessed or filled way w, with old age a: every way in the set with age < a increments by 1, and w becomes 0. All other sets are untouched.
- The tag array update and the LRU update land on the same edge as the response register. A lookup in the next cycle therefore sees the new state, so a same-address request back to back after a miss hits.
- Counters: on each accepted request, hit_count or miss_count increments by 1. Each holds at 2^CNT_W-1 and never wraps.
- clr_stats=1: both counters go to 0 on that edge. If an accepted request arrives the same cycle, it is still counted, so the counters become 0 plus that request (1 in the relevant counter).
- flush=1: all valid bits clear and ages reset to w in one edge. Any req_valid in that cycle is dropped: resp_valid=0 next cycle, counters unchanged. flush does not clear the counters.
- If both flush and clr_stats are asserted, both actions take effect.
- When no request is accepted: resp_valid=0, and hit and hit_way hold their last values.

Test Plan:
1. SETS=4, WAYS=2, BLOCK_BYTES=4. Send addresses 0x00, 0x00, 0x03 -> responses miss, hit, hit (0x03 is the same block). hit_count=2, miss_count=1.
2. Continue with 0x10 (set 0, tag 1) -> miss, fills way1. Then 0x20 -> miss, evicts way0 (holding 0x00, the LRU) on hit_way=0. Then 0x10 -> hit on way1. Then 0x00 -> miss, evicts way0 (holding 0x20). Totals: hits=3, misses=4.
3. Fill all 4 sets, pulse flush together with req 0x00 -> no response the next cycle, counters unchanged. Then 0x00 -> miss.
4. Pulse clr_stats together with an accepted hit -> the next cycle shows hit_count=1, miss_count=0.
5. Assert rst asynchronously between edges while requests are streaming -> all outputs are 0 immediately. After release, a previously cached address misses.
6. CNT_W=3: 9 consecutive hits -> hit_count saturates at 7.

Source files
------------

// File: rtl/cache_sa_lru.sv
// N-way set-associative tag-only cache model with true-LRU replacement,
// one lookup per cycle, 1-cycle response latency and saturating hit/miss counters.
module cache_sa_lru #(
    parameter int ADDR_W      = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 4,
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     flush,
    input  logic                     clr_stats,
    output logic                     resp_valid,
    output logic                     hit,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [WAY_W-1:0] way_t;

    logic line_valid [SETS][WAYS];
    tag_t line_tag   [SETS][WAYS];
    way_t line_age   [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    tag_t             tag;
    logic             accept;

    assign idx    = req_addr[OFF_W +: IDX_W];
    assign tag    = req_addr[ADDR_W-1 -: TAG_W];
    assign accept = req_valid && !flush;

    logic lk_hit, inv_found;
    way_t lk_way, inv_way, lru_way, acc_way, acc_age;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        // Scan high to low so the lowest-index invalid way is the one kept.
        for (int w = WAYS-1; w >= 0; w--) begin
            if (line_valid[idx][w] && line_tag[idx][w] == tag) begin
                lk_hit = 1'b1;
                lk_way = way_t'(w);
            end
            if (!line_valid[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = way_t'(w);
            end
            if (line_age[idx][w] == way_t'(WAYS-1)) lru_way = way_t'(w);
        end
        acc_way = lk_hit ? lk_way : (inv_found ? inv_way : lru_way);
        acc_age = line_age[idx][acc_way];
    end

    logic [CNT_W-1:0] hit_base, miss_base, hit_next, miss_next;

    // Clear happens first, so a same-cycle accepted request counts from zero.
    always_comb begin
        hit_base  = clr_stats ? '0 : hit_count;
        miss_base = clr_stats ? '0 : miss_count;
        hit_next  = hit_base;
        miss_next = miss_base;
        if (accept && lk_hit && hit_base != CNT_MAX)
            hit_next = hit_base + CNT_W'(1);
        if (accept && !lk_hit && miss_base != CNT_MAX)
            miss_next = miss_base + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the line arrays are flops, not RAM, so they can and must be reset to a defined state.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_valid[s][w] <= 1'b0;
                    line_tag[s][w]   <= '0;
                    line_age[s][w]   <= way_t'(w);
                end
            end
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            hit_way    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= accept;
            hit_count  <= hit_next;
            miss_count <= miss_next;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        line_valid[s][w] <= 1'b0;
                        line_age[s][w]   <= way_t'(w);
                    end
                end
            end else if (req_valid) begin
                hit                      <= lk_hit;
                hit_way                  <= acc_way;
                line_valid[idx][acc_way] <= 1'b1;
                line_tag[idx][acc_way]   <= tag;
                for (int w = 0; w < WAYS; w++) begin
                    if (way_t'(w) == acc_way)
                        line_age[idx][w] <= '0;
                    else if (line_age[idx][w] < acc_age)
                        line_age[idx][w] <= line_age[idx][w] + way_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_sa_lru.sv
// Scoreboard bench for cache_sa_lru: an MRU-ordered reference model predicts each
// response, pushes it to a queue, and the queue is popped when the DUT answers.
module tb_cache_sa_lru;

    localparam int ADDR_W      = 32;
    localparam int SETS        = 4;
    localparam int WAYS        = 2;
    localparam int BLOCK_BYTES = 4;
    localparam int CNT_W       = 3;
    localparam int WAY_W       = $clog2(WAYS);
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              flush = 1'b0;
    logic              clr_stats = 1'b0;
    logic              resp_valid;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    cache_sa_lru #(
        .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS),
        .BLOCK_BYTES(BLOCK_BYTES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .flush(flush), .clr_stats(clr_stats), .resp_valid(resp_valid),
        .hit(hit), .hit_way(hit_way), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int way;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: per-set valid/tag plus an MRU-first ordering of ways.
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_tag   [SETS][WAYS];
    int          m_order [SETS][WAYS];
    int          m_hc, m_mc;
    bit          m_last_hit;
    int          m_last_way;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s][w] = w;
            end
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_tag[s][w] = '0;
        m_hc = 0;
        m_mc = 0;
        m_last_hit = 1'b0;
        m_last_way = 0;
    endtask

    task automatic model_access(input logic [31:0] a, output bit h, output int way);
        int s, p;
        logic [31:0] t;
        s   = int'((a / BLOCK_BYTES) % SETS);
        t   = a / (BLOCK_BYTES * SETS);
        h   = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                h = 1'b1;
                way = w;
            end
        if (!h) begin
            for (int w = WAYS-1; w >= 0; w--)
                if (!m_valid[s][w]) way = w;
            if (way < 0) way = m_order[s][WAYS-1];
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
        end
        p = 0;
        for (int i = 0; i < WAYS; i++)
            if (m_order[s][i] == way) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = way;
    endtask

    task automatic do_cycle(input bit v, input logic [31:0] a, input bit f, input bit c);
        bit   h;
        int   way;
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        flush     = f;
        clr_stats = c;
        if (c) begin
            m_hc = 0;
            m_mc = 0;
        end
        if (f) begin
            model_flush();
        end else if (v) begin
            model_access(a, h, way);
            if (h) m_hc = (m_hc < CNT_MAX) ? m_hc + 1 : m_hc;
            else   m_mc = (m_mc < CNT_MAX) ? m_mc + 1 : m_mc;
            e.hit = h;
            e.way = way;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("hit", 32'(hit), 32'(e.hit));
            check("hit_way", 32'(hit_way), e.way);
            m_last_hit = e.hit;
            m_last_way = e.way;
        end else begin
            check("resp_valid_idle", 32'(resp_valid), 32'd0);
            check("hit_hold", 32'(hit), 32'(m_last_hit));
            check("hit_way_hold", 32'(hit_way), m_last_way);
        end
        check("hit_count", 32'(hit_count), m_hc);
        check("miss_count", 32'(miss_count), m_mc);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, "_hit"}, 32'(hit), 32'd0);
        check({name, "_hit_way"}, 32'(hit_way), 32'd0);
        check({name, "_hit_count"}, 32'(hit_count), 32'd0);
        check({name, "_miss_count"}, 32'(miss_count), 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Same block hits after the first miss.
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(1, 32'h03, 0, 0);

        // LRU eviction in set 0.
        do_cycle(1, 32'h10, 0, 0);
        do_cycle(1, 32'h20, 0, 0);
        do_cycle(1, 32'h10, 0, 0);
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(0, 32'h00, 0, 0);

        // Clear stats, fill remaining sets, then flush with a dropped request.
        do_cycle(0, 32'h00, 0, 1);
        do_cycle(1, 32'h04, 0, 0);
        do_cycle(1, 32'h08, 0, 0);
        do_cycle(1, 32'h0C, 0, 0);
        do_cycle(1, 32'h00, 1, 0);
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(1, 32'h04, 0, 0);

        // clr_stats together with an accepted hit counts that hit.
        do_cycle(1, 32'h00, 0, 1);

        // Hit counter saturation.
        for (int i = 0; i < 9; i++) do_cycle(1, 32'h00, 0, 0);

        // flush and clr_stats together.
        do_cycle(1, 32'h04, 1, 1);
        do_cycle(1, 32'h04, 0, 0);

        // Randomised traffic over a small address range.
        for (int i = 0; i < 80; i++)
            do_cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 127)),
                     $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0);

        // Asynchronous reset mid-stream.
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(1, 32'h00, 0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h00;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sb.delete();
        model_reset();
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        do_cycle(0, 32'h00, 0, 0);
        do_cycle(1, 32'h00, 0, 0);
        do_cycle(1, 32'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
